// File: rtl/adder_ctrl_p_if.sv
// FIFO-read and register-file-write signals shared by the adder controller and its memories.
// The master modport is the controller side.
interface adder_ctrl_p_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 4
);
  logic [CNT_W-1:0]  fifo_data_count;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_rd_en;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_wAddr;
  logic [DATA_W-1:0] rf_wData;

  modport master (
    input  fifo_data_count, fifo_dout,
    output fifo_rd_en, rf_we, rf_wAddr, rf_wData
  );

  modport slave (
    output fifo_data_count, fifo_dout,
    input  fifo_rd_en, rf_we, rf_wAddr, rf_wData
  );
endinterface

// File: rtl/adder_ctrl_p.sv
// Adder controller: pops operands from the FIFO in pairs and writes their sums (mode 0)
// or one accumulated total (mode 1) into the register file, with a sticky carry-out flag.
module adder_ctrl_p #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 op_start,
  input  logic                 op_clear,
  input  logic                 mode,
  adder_ctrl_p_if.master       bus,
  output logic                 op_done,
  output logic [1:0]           state,
  output logic                 ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_OUT  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic              popa_q, popa_d;
  logic              popb_q, popb_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              ovf_q, ovf_d;

  logic              fifo_nz;
  logic              rd_en;
  logic              we;
  logic [DATA_W:0]   sum1, sum2;
  logic              carry;

  function automatic logic [DATA_W:0] add_c(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign fifo_nz = (bus.fifo_data_count != '0);

  // Mode 0 feeds a zero accumulator, so only the second addition can carry there.
  assign sum1  = add_c(mode_q ? acc_q : '0, opa_q);
  assign sum2  = add_c(sum1[DATA_W-1:0], opb_q);
  assign carry = sum1[DATA_W] | sum2[DATA_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      waddr_q <= '0;
      mode_q  <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      popa_q  <= 1'b0;
      popb_q  <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      mode_q  <= mode_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      popa_q  <= popa_d;
      popb_q  <= popb_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    waddr_d = waddr_q;
    mode_d  = mode_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    popa_d  = popa_q;
    popb_d  = popb_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (op_clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      waddr_d = '0;
      opa_d   = '0;
      opb_d   = '0;
      popa_d  = 1'b0;
      popb_d  = 1'b0;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_start) begin
            if (fifo_nz) begin
              state_d = S_EXEC;
              cnt_d   = '0;
              mode_d  = mode;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_EXEC: begin
          // A pop flag remembers whether the word arriving next cycle is real or padding.
          case (cnt_q)
            2'd0: begin
              popa_d = rd_en;
              cnt_d  = 2'd1;
            end
            2'd1: begin
              opa_d  = popa_q ? bus.fifo_dout : '0;
              popb_d = rd_en;
              cnt_d  = 2'd2;
            end
            default: begin
              opb_d   = popb_q ? bus.fifo_dout : '0;
              cnt_d   = '0;
              state_d = S_OUT;
            end
          endcase
        end
        S_OUT: begin
          ovf_d = ovf_q | carry;
          if (mode_q) acc_d = sum2[DATA_W-1:0];
          if (we) waddr_d = waddr_q + ADDR_W'(1);
          cnt_d   = '0;
          state_d = fifo_nz ? S_EXEC : S_DONE;
        end
        default: begin
          if (!op_start) begin
            state_d = S_IDLE;
            acc_d   = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    rd_en = (state_q == S_EXEC) && (cnt_q != 2'd2) && fifo_nz;
    we    = (state_q == S_OUT) && (!mode_q || !fifo_nz);
    bus.fifo_rd_en = rd_en;
    bus.rf_we      = we;
    bus.rf_wAddr   = waddr_q;
    bus.rf_wData   = we ? sum2[DATA_W-1:0] : '0;
    op_done        = (state_q == S_DONE);
    state          = state_q;
    ovf            = ovf_q;
  end

endmodule
